uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Byte-level command decoder that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle `rx_valid`/`rx_data`/`rx_break` strobes and assembles fixed-format read/write commands (opcode, big-endian address, big-endian write data). It presents each command on a valid/ready handshake to the demo's bus master, and reports protocol errors (bad opcode, inter-byte timeout, overrun, break) as single-cycle pulses with a code.

## Interface
Parameters:
- `ADDR_BYTES`, default 4: address bytes per command; `cmd_addr` width is 8*ADDR_BYTES.
- `DATA_BYTES`, default 4: write-data bytes per write command; `cmd_wdata` width is 8*DATA_BYTES.
- `TIMEOUT_CYCLES`, default 5_000_000: maximum idle clocks between bytes inside a command; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, a byte has been received; no backpressure.
- `rx_data` in 8: received byte; sampled only when `rx_valid`=1.
- `rx_break` in 1: break detected; qualified by `rx_valid`.
- `cmd_valid` out 1: command available.
- `cmd_ready` in 1: consumer accepts; transfer occurs when `cmd_valid & cmd_ready`.
- `cmd_write` out 1: 1 = write, 0 = read.
- `cmd_addr` out 8*ADDR_BYTES: command address.
- `cmd_wdata` out 8*DATA_BYTES: write data; all zeros for reads.
- `err_pulse` out 1: one-cycle error strobe.
- `err_code` out 3: error code, held until the next error. 1 = bad opcode, 2 = timeout, 3 = overrun, 4 = break, 5 = checksum.

## Operation
- Opcodes: 0x57 ('W') is a write and is followed by ADDR_BYTES then DATA_BYTES. 0x52 ('R') is a read and is followed by ADDR_BYTES. Multi-byte fields are sent MSB first and shifted in from the LSB end.
- FSM states:
  - IDLE: on a byte, 'W'/'R' → ADDR, latch `cmd_write`, clear the shift registers. Any other byte → error 1, stay in IDLE.
  - ADDR: collect ADDR_BYTES. Then, for a write → DATA. For a read → ISSUE (or CHECK when the checksum is enabled).
  - DATA: collect DATA_BYTES, then → ISSUE (or CHECK).
  - CHECK (checksum builds only): one byte. If it matches → ISSUE. If it mismatches → error 5, → IDLE.
  - ISSUE: hold `cmd_valid`=1 and all outputs stable until the handshake, then → IDLE.
- Byte counter: width $clog2(max(ADDR_BYTES,DATA_BYTES))+1. It clears on every state entry and increments per accepted byte.
- Timeout counter: runs only in ADDR, DATA and CHECK, and clears on every accepted byte. When it reaches TIMEOUT_CYCLES-1: error 2, → IDLE, partial command discarded.
- Overrun: a byte arriving in ISSUE is dropped and raises error 3. The pending command is kept and ISSUE continues.
- Break: `rx_valid & rx_break` in any state has priority over data decoding. It raises error 4 and forces IDLE, dropping any pending command including one in ISSUE. In IDLE it still raises error 4.
- Simultaneous events: a timeout expiring in the same cycle as a byte arrives: the byte wins, counter clears, no error. A handshake in ISSUE in the same cycle as a byte arriving: the command transfers, → IDLE, and the byte is treated as overrun (error 3, dropped).

## Timing
- Reset values: `cmd_valid`=0, `cmd_write`=0, `cmd_addr`=0, `cmd_wdata`=0, `err_pulse`=0, `err_code`=0. FSM resets to IDLE and all counters to 0.
- `cmd_valid` rises on the clock edge after the `rx_valid` cycle of the final byte (1-cycle latency).
- `cmd_valid` falls on the edge after the handshake. The earliest next `cmd_valid` follows the next command's final byte.
- `err_pulse` is registered: it asserts the cycle after the causing event, for exactly 1 cycle. `err_code` updates in that same cycle.
- Reset asserted mid-command: outputs clear asynchronously and the partial command is lost. No error is reported on reset release.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined: every command carries a trailing checksum byte equal to the XOR of the opcode and all payload bytes. The CHECK state and error 5 exist.
- Not defined: no CHECK state, no checksum byte, error 5 is never produced, and commands issue directly after the last payload byte.

## Test plan
- Read, macro off: bytes 52 12 34 56 78 with `cmd_ready`=1 → one-cycle `cmd_valid`, `cmd_write`=0, `cmd_addr`=0x12345678, `cmd_wdata`=0.
- Write with backpressure: bytes 57 00 00 10 00 DE AD BE EF, `cmd_ready` held low for 20 cycles → `cmd_valid` held with `cmd_addr`=0x00001000 and `cmd_wdata`=0xDEADBEEF until `cmd_ready`=1. A byte 0x41 injected while waiting → error 3, and the command is still delivered intact.
- Bad opcode: byte 0x5A → `err_pulse` for one cycle with `err_code`=1, no `cmd_valid`. A following valid 'R' command decodes normally.
- Timeout: TIMEOUT_CYCLES=100, bytes 52 12 then silence → error 2 at exactly 100 cycles after byte 0x12. A subsequent 'R' command decodes cleanly.
- Break: 'W' plus 3 address bytes, then `rx_valid` with `rx_break`=1 → error 4, state IDLE, no command. Repeat the break during ISSUE → pending command dropped.
- Checksum, macro on: 52 00 00 00 04 56 → read of 0x00000004. The same command with checksum 0x57 → error 5 and no `cmd_valid`.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder_if
// Description : Command handshake bundle between the UART command decoder
//               and the bus master that executes the decoded commands.
//               The master modport belongs to the decoder, which produces
//               the commands; the slave modport belongs to the consumer.
// Signals     : cmd_valid  - command available
//               cmd_ready  - consumer accepts (transfer on valid & ready)
//               cmd_write  - 1 = write, 0 = read
//               cmd_addr   - command address, 8*ADDR_BYTES bits
//               cmd_wdata  - write data, 8*DATA_BYTES bits, zero for reads
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [8*ADDR_BYTES-1:0] cmd_addr;
  logic [8*DATA_BYTES-1:0] cmd_wdata;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Assembles fixed-format read/write commands from the byte
//               strobes of a UART receiver and presents them on a
//               valid/ready handshake. Protocol errors are reported as
//               one-cycle pulses with a code held until the next error.
//               Frame: 'W' addr[ADDR_BYTES] data[DATA_BYTES]
//                      'R' addr[ADDR_BYTES]
//               Multi-byte fields are sent MSB first.
// Build macro : UART_CMD_CHECKSUM_EN - when defined, each command carries a
//               trailing byte equal to the XOR of opcode and payload; a
//               mismatch reports error 5 and discards the command.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               rx_valid  - one-cycle byte strobe from the receiver
//               rx_data   - received byte
//               rx_break  - break indication, qualified by rx_valid
//               cmd       - command handshake (master modport)
//               err_pulse - one-cycle error strobe
//               err_code  - 1 opcode, 2 timeout, 3 overrun, 4 break,
//                           5 checksum
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int ADDR_BYTES     = 4,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               rx_valid,
  input  wire logic [7:0]         rx_data,
  input  wire logic               rx_break,
  uart_cmd_decoder_if.master      cmd,
  output logic                    err_pulse,
  output logic [2:0]              err_code
);

  localparam int AW        = 8 * ADDR_BYTES;
  localparam int DW        = 8 * DATA_BYTES;
  localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES) + 1;
  localparam int TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0] c_OP_WRITE     = 8'h57;
  localparam logic [7:0] c_OP_READ      = 8'h52;
  localparam logic [2:0] c_ERR_OPCODE   = 3'd1;
  localparam logic [2:0] c_ERR_TIMEOUT  = 3'd2;
  localparam logic [2:0] c_ERR_OVERRUN  = 3'd3;
  localparam logic [2:0] c_ERR_BREAK    = 3'd4;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [2:0] c_ERR_CHECKSUM = 3'd5;
`endif

  localparam logic [CNT_W-1:0] c_ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0]  c_TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ISSUE = 3'd4
`ifdef UART_CMD_CHECKSUM_EN
    ,
    S_CHECK = 3'd3
`endif
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_cmd_valid;
  logic             r_cmd_write;
  logic [AW-1:0]    r_cmd_addr;
  logic [DW-1:0]    r_cmd_wdata;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic w_break;
  logic w_timeout;
  logic w_xfer;

  // A break is only meaningful together with the byte strobe.
  assign w_break   = rx_valid & rx_break;
  // A byte arriving on the expiry cycle is handled first, so the timeout
  // branch below is only reached when rx_valid is low.
  assign w_timeout = (r_to_cnt == c_TO_LAST);
  assign w_xfer    = r_cmd_valid & cmd.cmd_ready;

  assign cmd.cmd_valid = r_cmd_valid;
  assign cmd.cmd_write = r_cmd_write;
  assign cmd.cmd_addr  = r_cmd_addr;
  assign cmd.cmd_wdata = r_cmd_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_to_cnt    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      err_pulse   <= 1'b0;
      err_code    <= 3'd0;
`ifdef UART_CMD_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (w_break) begin
        // Break overrides everything, including a command awaiting handshake.
        err_pulse   <= 1'b1;
        err_code    <= c_ERR_BREAK;
        r_state     <= S_IDLE;
        r_cmd_valid <= 1'b0;
        r_byte_cnt  <= '0;
        r_to_cnt    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_to_cnt <= '0;
            if (rx_valid) begin
              if (rx_data == c_OP_WRITE || rx_data == c_OP_READ) begin
                r_state     <= S_ADDR;
                r_cmd_write <= (rx_data == c_OP_WRITE);
                // Output registers double as the field shift registers.
                r_cmd_addr  <= '0;
                r_cmd_wdata <= '0;
                r_byte_cnt  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                r_csum      <= rx_data;
`endif
              end else begin
                err_pulse <= 1'b1;
                err_code  <= c_ERR_OPCODE;
              end
            end
          end

          S_ADDR: begin
            if (rx_valid) begin
              r_to_cnt   <= '0;
              r_cmd_addr <= (r_cmd_addr << 8) | AW'(rx_data);
`ifdef UART_CMD_CHECKSUM_EN
              r_csum     <= r_csum ^ rx_data;
`endif
              if (r_byte_cnt == c_ADDR_LAST) begin
                r_byte_cnt <= '0;
                if (r_cmd_write) begin
                  r_state <= S_DATA;
                end else begin
`ifdef UART_CMD_CHECKSUM_EN
                  r_state <= S_CHECK;
`else
                  r_state     <= S_ISSUE;
                  r_cmd_valid <= 1'b1;
`endif
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
              end
            end else if (w_timeout) begin
              err_pulse  <= 1'b1;
              err_code   <= c_ERR_TIMEOUT;
              r_state    <= S_IDLE;
              r_byte_cnt <= '0;
              r_to_cnt   <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end

          S_DATA: begin
            if (rx_valid) begin
              r_to_cnt    <= '0;
              r_cmd_wdata <= (r_cmd_wdata << 8) | DW'(rx_data);
`ifdef UART_CMD_CHECKSUM_EN
              r_csum      <= r_csum ^ rx_data;
`endif
              if (r_byte_cnt == c_DATA_LAST) begin
                r_byte_cnt <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                r_state    <= S_CHECK;
`else
                r_state     <= S_ISSUE;
                r_cmd_valid <= 1'b1;
`endif
              end else begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
              end
            end else if (w_timeout) begin
              err_pulse  <= 1'b1;
              err_code   <= c_ERR_TIMEOUT;
              r_state    <= S_IDLE;
              r_byte_cnt <= '0;
              r_to_cnt   <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end

`ifdef UART_CMD_CHECKSUM_EN
          S_CHECK: begin
            if (rx_valid) begin
              r_to_cnt   <= '0;
              r_byte_cnt <= '0;
              if (rx_data == r_csum) begin
                r_state     <= S_ISSUE;
                r_cmd_valid <= 1'b1;
              end else begin
                err_pulse <= 1'b1;
                err_code  <= c_ERR_CHECKSUM;
                r_state   <= S_IDLE;
              end
            end else if (w_timeout) begin
              err_pulse  <= 1'b1;
              err_code   <= c_ERR_TIMEOUT;
              r_state    <= S_IDLE;
              r_byte_cnt <= '0;
              r_to_cnt   <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
`endif

          S_ISSUE: begin
            r_to_cnt <= '0;
            if (w_xfer) begin
              r_cmd_valid <= 1'b0;
              r_state     <= S_IDLE;
              r_byte_cnt  <= '0;
            end
            // Any byte here is dropped, even on the handshake cycle.
            if (rx_valid) begin
              err_pulse <= 1'b1;
              err_code  <= c_ERR_OVERRUN;
            end
          end

          default: begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_byte_cnt  <= '0;
            r_to_cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Directed self-checking bench for uart_cmd_decoder with
//               ADDR_BYTES=4, DATA_BYTES=4, TIMEOUT_CYCLES=100. Checksum
//               cases are compiled in when UART_CMD_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

  localparam int AB = 4;
  localparam int DB = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_break = 1'b0;
  logic       err_pulse;
  logic [2:0] err_code;

  always #5 clk = ~clk;

  uart_cmd_decoder_if #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) cmd_if ();

  uart_cmd_decoder #(
    .ADDR_BYTES    (AB),
    .DATA_BYTES    (DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_break (rx_break),
    .cmd      (cmd_if),
    .err_pulse(err_pulse),
    .err_code (err_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state: error pulses, transfers, stability while stalled.
  int          err_cnt = 0;
  logic [2:0]  last_code = 3'd0;
  int          xfer_cnt = 0;
  logic        xfer_write = 1'b0;
  logic [31:0] xfer_addr = '0;
  logic [31:0] xfer_wdata = '0;
  int          unstable = 0;
  logic        prev_hold = 1'b0;
  logic        prev_write = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (err_pulse) begin
      err_cnt++;
      last_code = err_code;
    end
    if (prev_hold && cmd_if.cmd_valid &&
        (cmd_if.cmd_addr !== prev_addr || cmd_if.cmd_wdata !== prev_wdata ||
         cmd_if.cmd_write !== prev_write))
      unstable++;
    if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      xfer_cnt++;
      xfer_write = cmd_if.cmd_write;
      xfer_addr  = cmd_if.cmd_addr;
      xfer_wdata = cmd_if.cmd_wdata;
    end
    prev_hold  = cmd_if.cmd_valid && !cmd_if.cmd_ready;
    prev_addr  = cmd_if.cmd_addr;
    prev_wdata = cmd_if.cmd_wdata;
    prev_write = cmd_if.cmd_write;
  end

  // Drives one byte for one cycle; returns on the falling edge right after
  // the rising edge that sampled it.
  task automatic send_byte(input logic [7:0] b, input logic brk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_break = brk;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    logic [7:0] cs;
    cs = op;
    send_byte(op, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      send_byte(addr[8*i +: 8], 1'b0);
      cs = cs ^ addr[8*i +: 8];
    end
    if (op == 8'h57) begin
      for (int i = 3; i >= 0; i--) begin
        send_byte(wdata[8*i +: 8], 1'b0);
        cs = cs ^ wdata[8*i +: 8];
      end
    end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cs, 1'b0);
`else
    cs = 8'h00;
`endif
  endtask

  int e0;
  int x0;
  int n;

  initial begin
    cmd_if.cmd_ready = 1'b1;
    idle(3);
    check("rst_cmd_valid", cmd_if.cmd_valid, 1'b0);
    check("rst_cmd_write", cmd_if.cmd_write, 1'b0);
    check("rst_cmd_addr",  cmd_if.cmd_addr,  32'h0);
    check("rst_cmd_wdata", cmd_if.cmd_wdata, 32'h0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_err_code",  err_code,  3'd0);
    rst = 1'b0;
    idle(2);

    // Read, ready held high: one-cycle valid right after the final byte.
    e0 = err_cnt; x0 = xfer_cnt;
    send_cmd(8'h52, 32'h12345678, 32'h0);
    check("rd_valid_latency", cmd_if.cmd_valid, 1'b1);
    @(negedge clk);
    check("rd_valid_one_cycle", cmd_if.cmd_valid, 1'b0);
    idle(2);
    check("rd_xfer_cnt", xfer_cnt - x0, 1);
    check("rd_write", xfer_write, 1'b0);
    check("rd_addr", xfer_addr, 32'h12345678);
    check("rd_wdata", xfer_wdata, 32'h0);
    check("rd_no_err", err_cnt - e0, 0);

    // Write with backpressure and an overrun byte while waiting.
    cmd_if.cmd_ready = 1'b0;
    e0 = err_cnt; x0 = xfer_cnt;
    send_cmd(8'h57, 32'h00001000, 32'hDEADBEEF);
    check("wr_valid", cmd_if.cmd_valid, 1'b1);
    idle(8);
    send_byte(8'h41, 1'b0);
    check("ovr_pulse", err_pulse, 1'b1);
    check("ovr_code", err_code, 3'd3);
    idle(10);
    check("wr_valid_held", cmd_if.cmd_valid, 1'b1);
    check("wr_no_early_xfer", xfer_cnt - x0, 0);
    cmd_if.cmd_ready = 1'b1;
    idle(3);
    check("wr_xfer_cnt", xfer_cnt - x0, 1);
    check("wr_write", xfer_write, 1'b1);
    check("wr_addr", xfer_addr, 32'h00001000);
    check("wr_wdata", xfer_wdata, 32'hDEADBEEF);
    check("wr_stable", unstable, 0);
    check("wr_err_cnt", err_cnt - e0, 1);
    check("wr_valid_fell", cmd_if.cmd_valid, 1'b0);

    // Bad opcode, then a normal read.
    x0 = xfer_cnt;
    send_byte(8'h5A, 1'b0);
    check("badop_pulse", err_pulse, 1'b1);
    check("badop_code", err_code, 3'd1);
    @(negedge clk);
    check("badop_pulse_width", err_pulse, 1'b0);
    check("badop_code_held", err_code, 3'd1);
    check("badop_no_valid", cmd_if.cmd_valid, 1'b0);
    send_cmd(8'h52, 32'h00000004, 32'h0);
    idle(2);
    check("badop_next_xfer", xfer_cnt - x0, 1);
    check("badop_next_addr", xfer_addr, 32'h00000004);

    // Timeout: error exactly TO edges after the last byte's sampling edge.
    x0 = xfer_cnt;
    send_byte(8'h52, 1'b0);
    send_byte(8'h12, 1'b0);
    n = 0;
    for (int k = 1; k <= 3 * TO; k++) begin
      @(posedge clk);
      #1;
      if (err_pulse) begin
        n = k;
        break;
      end
    end
    check("to_cycles", n, TO);
    check("to_code", err_code, 3'd2);
    idle(2);
    send_cmd(8'h52, 32'hA1B2C3D4, 32'h0);
    idle(2);
    check("to_next_xfer", xfer_cnt - x0, 1);
    check("to_next_addr", xfer_addr, 32'hA1B2C3D4);

    // Byte arriving on the timeout expiry cycle wins.
    e0 = err_cnt; x0 = xfer_cnt;
    send_byte(8'h52, 1'b0);
    send_byte(8'hAA, 1'b0);
    idle(TO - 2);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h52 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 1'b0);
`endif
    idle(2);
    check("to_race_no_err", err_cnt - e0, 0);
    check("to_race_addr", xfer_addr, 32'hAABBCCDD);
    check("to_race_xfer", xfer_cnt - x0, 1);

    // Break mid-command.
    x0 = xfer_cnt;
    send_byte(8'h57, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b1);
    check("brk_pulse", err_pulse, 1'b1);
    check("brk_code", err_code, 3'd4);
    idle(12);
    check("brk_no_cmd", xfer_cnt - x0, 0);
    check("brk_no_valid", cmd_if.cmd_valid, 1'b0);

    // Break while a command waits in ISSUE drops it.
    cmd_if.cmd_ready = 1'b0;
    send_cmd(8'h52, 32'h11223344, 32'h0);
    check("brk_issue_valid", cmd_if.cmd_valid, 1'b1);
    e0 = err_cnt;
    send_byte(8'h00, 1'b1);
    check("brk_issue_dropped", cmd_if.cmd_valid, 1'b0);
    cmd_if.cmd_ready = 1'b1;
    idle(3);
    check("brk_issue_no_xfer", xfer_cnt - x0, 0);
    check("brk_issue_code", last_code, 3'd4);

    // Break in IDLE still reports.
    send_byte(8'h55, 1'b1);
    check("brk_idle_pulse", err_pulse, 1'b1);
    idle(2);
    check("brk_err_cnt", err_cnt - e0, 2);

    // Handshake and byte in the same cycle: transfer plus overrun.
    cmd_if.cmd_ready = 1'b0;
    e0 = err_cnt; x0 = xfer_cnt;
    send_cmd(8'h52, 32'hCAFEF00D, 32'h0);
    idle(2);
    cmd_if.cmd_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    @(negedge clk);
    rx_valid = 1'b0;
    check("hs_ovr_valid_fell", cmd_if.cmd_valid, 1'b0);
    check("hs_ovr_code", err_code, 3'd3);
    idle(2);
    check("hs_ovr_xfer", xfer_cnt - x0, 1);
    check("hs_ovr_addr", xfer_addr, 32'hCAFEF00D);
    check("hs_ovr_err_cnt", err_cnt - e0, 1);

    // Reset in the middle of a command.
    e0 = err_cnt; x0 = xfer_cnt;
    send_byte(8'h57, 1'b0);
    send_byte(8'h99, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_addr", cmd_if.cmd_addr, 32'h0);
    check("mid_rst_write", cmd_if.cmd_write, 1'b0);
    check("mid_rst_code", err_code, 3'd0);
    idle(2);
    rst = 1'b0;
    send_cmd(8'h52, 32'h0BADF00D, 32'h0);
    idle(2);
    check("mid_rst_next_addr", xfer_addr, 32'h0BADF00D);
    check("mid_rst_no_err", err_cnt - e0, 0);

`ifdef UART_CMD_CHECKSUM_EN
    // Checksum good and bad.
    x0 = xfer_cnt;
    send_byte(8'h52, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h56, 1'b0);
    idle(2);
    check("cs_good_xfer", xfer_cnt - x0, 1);
    check("cs_good_addr", xfer_addr, 32'h00000004);
    send_byte(8'h52, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h57, 1'b0);
    check("cs_bad_pulse", err_pulse, 1'b1);
    check("cs_bad_code", err_code, 3'd5);
    check("cs_bad_no_valid", cmd_if.cmd_valid, 1'b0);
    idle(3);
    check("cs_bad_no_xfer", xfer_cnt - x0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
